sat_bcp_init: RTL and testbench

SAT_BCP_INIT -- requirements
Module: sat_bcp_init

---
 rtl/sat_bcp_init.sv | 167 ++++++++++++++++
 tb/tb_sat_bcp_init.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sat_bcp_init.sv
// Clause-bank loader from a parameter ROM plus a registered Boolean constraint
// propagation check (conflict / unit / all-satisfied) over the loaded clauses.

module sat_bcp_clause #(
   parameter int NV = 4,
   parameter int VW = (NV > 1) ? $clog2(NV) : 1
) (
   input  logic [2*NV-1:0] c,
   input  logic [NV-1:0]   asg_def,
   input  logic [NV-1:0]   asg_val,
   output logic            sat,
   output logic            conf,
   output logic            unit,
   output logic [VW-1:0]   uvar,
   output logic            uval
);
   logic one_u, many_u;

   // Positive and negative literals of the same variable are counted separately,
   // so a tautological pair with that variable unassigned is never a unit.
   always_comb begin
      sat    = 1'b0;
      one_u  = 1'b0;
      many_u = 1'b0;
      uvar   = '0;
      uval   = 1'b0;
      for (int i = 0; i < NV; i++) begin
         if (asg_def[i]) begin
            if ((c[NV+i] && asg_val[i]) || (c[i] && !asg_val[i]))
               sat = 1'b1;
         end else begin
            if (c[NV+i]) begin
               if (one_u) many_u = 1'b1;
               else begin
                  one_u = 1'b1;
                  uvar  = i[VW-1:0];
                  uval  = 1'b1;
               end
            end
            if (c[i]) begin
               if (one_u) many_u = 1'b1;
               else begin
                  one_u = 1'b1;
                  uvar  = i[VW-1:0];
                  uval  = 1'b0;
               end
            end
         end
      end
      conf = !sat && !one_u;
      unit = !sat && one_u && !many_u;
   end
endmodule

module sat_bcp_init #(
   parameter int W     = 8,
   parameter int DEPTH = 8,
   parameter int NV    = 4,
   parameter logic [W*DEPTH-1:0] ROM_INIT =
      {8'h0C, 8'hC0, 8'h30, 8'h84, 8'h48, 8'h21, 8'h12, 8'h03},
   parameter int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int VW = (NV > 1) ? $clog2(NV) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             initial_sign,
   output logic [AW-1:0]    address,
   output logic [W-1:0]     wd,
   output logic             load_done,
   output logic [DEPTH-1:0] valid,
   input  logic [NV-1:0]    asg_def,
   input  logic [NV-1:0]    asg_val,
   output logic             conflict,
   output logic             unit_found,
   output logic [VW-1:0]    unit_var,
   output logic             unit_val,
   output logic             all_sat
);
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t                    state_q, state_d;
   logic                      we;
   logic                      last;
   logic [DEPTH-1:0][W-1:0]   clause;
   logic [DEPTH-1:0]          c_sat, c_conf, c_unit, c_uval;
   logic [DEPTH-1:0][VW-1:0]  c_uvar;
   logic                      any_conf, any_unit, every_sat, sel_uval;
   logic [VW-1:0]             sel_uvar;

   assign wd   = ROM_INIT[address*W +: W];
   assign last = (address == AW'(DEPTH-1));

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, LOAD: if (initial_sign) state_d = last ? DONE : LOAD;
         DONE:       state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      we        = (state_q != DONE) && initial_sign;
      load_done = (state_q == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         address <= '0;
         valid   <= '0;
         clause  <= '0;
      end else if (we) begin
         clause[address] <= wd;
         valid[address]  <= 1'b1;
         address         <= last ? '0 : address + AW'(1);
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_cl
      sat_bcp_clause #(.NV(NV), .VW(VW)) u_cl (
         .c       (clause[g]),
         .asg_def (asg_def),
         .asg_val (asg_val),
         .sat     (c_sat[g]),
         .conf    (c_conf[g]),
         .unit    (c_unit[g]),
         .uvar    (c_uvar[g]),
         .uval    (c_uval[g])
      );
   end

   // Scan high to low so the lowest-index unit clause ends up selected.
   always_comb begin
      any_conf  = |(valid & c_conf);
      any_unit  = |(valid & c_unit);
      every_sat = load_done && (&(c_sat | ~valid));
      sel_uvar  = '0;
      sel_uval  = 1'b0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (valid[i] && c_unit[i]) begin
            sel_uvar = c_uvar[i];
            sel_uval = c_uval[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         conflict   <= 1'b0;
         unit_found <= 1'b0;
         unit_var   <= '0;
         unit_val   <= 1'b0;
         all_sat    <= 1'b0;
      end else begin
         conflict   <= any_conf;
         unit_found <= any_unit;
         unit_var   <= sel_uvar;
         unit_val   <= sel_uval;
         all_sat    <= every_sat;
      end
   end
endmodule

// File: tb/tb_sat_bcp_init.sv
// Directed bench for sat_bcp_init: reset, partial/paused load, full load,
// BCP outcomes on the default ROM, DONE hold, and mid-load reset.

module tb_sat_bcp_init;
   logic       clk = 1'b0;
   logic       rst, initial_sign;
   logic [2:0] address;
   logic [7:0] wd;
   logic       load_done;
   logic [7:0] valid;
   logic [3:0] asg_def, asg_val;
   logic       conflict, unit_found, unit_val, all_sat;
   logic [1:0] unit_var;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] rom [8] = '{8'h03, 8'h12, 8'h21, 8'h48, 8'h84, 8'h30, 8'hC0, 8'h0C};

   sat_bcp_init dut (
      .clk(clk), .rst(rst), .initial_sign(initial_sign), .address(address),
      .wd(wd), .load_done(load_done), .valid(valid), .asg_def(asg_def),
      .asg_val(asg_val), .conflict(conflict), .unit_found(unit_found),
      .unit_var(unit_var), .unit_val(unit_val), .all_sat(all_sat)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bcp(input string tag, input logic cf, input logic uf,
                          input logic [1:0] uv, input logic ul, input logic as);
      chk({tag, ".conflict"},   32'(conflict),   32'(cf));
      chk({tag, ".unit_found"}, 32'(unit_found), 32'(uf));
      chk({tag, ".unit_var"},   32'(unit_var),   32'(uv));
      chk({tag, ".unit_val"},   32'(unit_val),   32'(ul));
      chk({tag, ".all_sat"},    32'(all_sat),    32'(as));
   endtask

   initial begin
      rst = 1'b1; initial_sign = 1'b1; asg_def = 4'h0; asg_val = 4'h0;

      // reset wins over load enable; outputs defined from first edge
      step();
      chk("rst1.address", 32'(address), 0);
      chk("rst1.valid", 32'(valid), 0);
      chk("rst1.load_done", 32'(load_done), 0);
      chk_bcp("rst1", 0, 0, 0, 0, 0);
      step(); step();
      chk("rst3.address", 32'(address), 0);

      // three loads then pause
      rst = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         step();
         chk("load.address", 32'(address), k);
         chk("load.load_done", 32'(load_done), 0);
      end
      initial_sign = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("pause.address", 32'(address), 3);
         chk("pause.load_done", 32'(load_done), 0);
      end
      chk("pause.valid", 32'(valid), 32'h07);
      for (int i = 0; i < 3; i++) chk("pause.clause", 32'(dut.clause[i]), 32'(rom[i]));
      chk("pause.clause3_empty", 32'(dut.clause[3]), 0);
      chk("pause.wd", 32'(wd), 32'h48);

      // resume from held address
      initial_sign = 1'b1;
      for (int k = 0; k < 4; k++) step();
      chk("resume.address7", 32'(address), 7);
      chk("resume.not_done", 32'(load_done), 0);
      step();
      chk("resume.wrap", 32'(address), 0);
      chk("resume.done", 32'(load_done), 1);
      chk("resume.valid", 32'(valid), 32'hFF);

      // fresh uninterrupted load
      rst = 1'b1; step(); rst = 1'b0;
      chk("reload.valid0", 32'(valid), 0);
      for (int k = 0; k < 8; k++) begin
         step();
         chk("full.address", 32'(address), (k + 1) % 8);
         chk("full.load_done", 32'(load_done), (k == 7) ? 1 : 0);
      end
      chk("full.valid", 32'(valid), 32'hFF);
      for (int i = 0; i < 8; i++) chk("full.clause", 32'(dut.clause[i]), 32'(rom[i]));

      // BCP vectors on the full bank
      initial_sign = 1'b0;
      step();
      chk_bcp("bcp_none", 0, 0, 0, 0, 0);
      asg_def = 4'h3; asg_val = 4'h3; step();
      chk_bcp("bcp_x0x1", 1, 0, 0, 0, 0);
      asg_def = 4'h1; asg_val = 4'h1; step();
      chk_bcp("bcp_x0", 0, 1, 1, 0, 0);
      asg_def = 4'h7; asg_val = 4'h7; step();
      chk_bcp("bcp_both", 1, 1, 3, 1, 0);
      asg_def = 4'hF; asg_val = 4'h5; step();
      chk_bcp("bcp_full", 1, 0, 0, 0, 0);

      // DONE ignores initial_sign
      for (int k = 0; k < 4; k++) begin
         initial_sign = ~initial_sign;
         step();
      end
      chk("done.address", 32'(address), 0);
      chk("done.load_done", 32'(load_done), 1);
      chk("done.valid", 32'(valid), 32'hFF);
      chk("done.clause3", 32'(dut.clause[3]), 32'h48);

      // reset mid-load at address 5
      rst = 1'b1; initial_sign = 1'b1; step(); rst = 1'b0;
      for (int k = 0; k < 5; k++) step();
      chk("mid.address5", 32'(address), 5);
      asg_def = 4'h3; asg_val = 4'h3; step();
      chk("mid.conflict_pre", 32'(conflict), 1);
      rst = 1'b1; step();
      chk("mid.address", 32'(address), 0);
      chk("mid.valid", 32'(valid), 0);
      chk("mid.clause0", 32'(dut.clause[0]), 0);
      chk("mid.load_done", 32'(load_done), 0);
      chk_bcp("mid", 0, 0, 0, 0, 0);
      rst = 1'b0; step();
      chk("mid.reload_addr", 32'(address), 1);
      chk("mid.reload_valid", 32'(valid), 32'h01);
      chk("mid.reload_clause0", 32'(dut.clause[0]), 32'h03);
      chk("mid.latency", 32'(conflict), 0);
      initial_sign = 1'b0; step();
      chk("mid.conflict_after", 32'(conflict), 1);
      chk("mid.hold_addr", 32'(address), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
